mdu_seq: RTL and testbench
==========================

# mdu_seq

Multi-cycle sequencer for the RV32M multiply/divide datapath. It accepts one operation per handshake, runs a 32-iteration radix-2 shift-add multiply or restoring divide, and returns a registered result with a one-cycle valid pulse. Divide-by-zero, signed overflow and illegal opcodes are resolved in a single cycle. It sits beside the ALU in the execute stage, and the pipeline control stalls on `busy`.

## Interface
- `XLEN`, default 32: operand/result width; the iteration count equals `XLEN`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  operation request; sampled only in IDLE.
- `mdu_op`  in  3  000 mul, 001 mulh, 010 div, 011 divu, 100 rem, 101 remu; 110 and 111 are illegal.
- `rs1`  in  XLEN  multiplicand / dividend; captured on acceptance.
- `rs2`  in  XLEN  multiplier / divisor; captured on acceptance.
- `flush`  in  1  synchronous abort; highest priority after `rst`.
- `busy`  out  1  high whenever state is not IDLE; decoded from the state register.
- `valid`  out  1  registered one-cycle pulse; `result` is meaningful in that cycle.
- `result`  out  XLEN  registered; holds the last completed value until the next completion.

## Operation
- States: IDLE, CALC, DONE.
- IDLE -> CALC: `start` and not `flush`, with no fast-path condition. The block latches the op and the operand magnitudes, latches the result sign, and clears the counter.
- IDLE -> DONE (fast path): `start` and not `flush` with one of the following. `result` is loaded on the same edge.
  - divu/div with `rs2`=0 -> 0xFFFFFFFF.
  - remu/rem with `rs2`=0 -> `rs1`.
  - div with `rs1`=0x80000000 and `rs2`=0xFFFFFFFF -> 0x80000000.
  - rem with the same operands -> 0.
  - illegal op -> 0.
- CALC: one iteration per cycle; the counter runs 0..XLEN-1. At count XLEN-1 the state goes to DONE and the sign-fixed result is loaded into `result`.
- DONE: `valid`=1 for exactly one cycle, then the state returns to IDLE.
- `start` in CALC or DONE is ignored, not queued. The requester must hold `start` until it sees `busy`.
- mul: unsigned shift-add of `rs1`*`rs2` into a 2*XLEN accumulator; the result is the low XLEN bits. Signed and unsigned give identical low bits.
- mulh: signed*signed. The block multiplies operand magnitudes, negates the 2*XLEN product when the signs differ, and returns the upper XLEN bits.
- divu/remu: restoring division on the unsigned operands. Each iteration shifts the remainder left, brings in the next dividend bit, subtracts the divisor when the remainder is greater than or equal to it, and shifts the quotient bit in.
- div/rem: the unsigned core runs on operand magnitudes. The quotient is negated when the operand signs differ. The remainder takes the sign of `rs1`.
- `flush`: from any state, go to IDLE on the next edge. `valid` is not asserted, `result` is unchanged and the counter is cleared. If `flush` and `start` arrive together in IDLE, the request is dropped.
- `rst`: immediate IDLE. The counter, internal registers and `result` go to 0, and `valid`=0.

## Timing
- Reset values: `busy`=0, `valid`=0, `result`=0.
- The request is accepted on the edge ending cycle T.
- Iterative ops:
  - `busy`=1 in cycles T+1..T+33.
  - CALC occupies T+1..T+32.
  - `valid`=1 and `result` is correct in T+33.
  - IDLE resumes in T+34, and the earliest next acceptance is the edge ending T+34.
- Fast path:
  - DONE in T+1, so `busy`=1 and `valid`=1 there.
  - IDLE resumes in T+2.
- Throughput: one iterative op per 34 cycles, or one fast-path op per 2 cycles.
- `flush` asserted in cycle F with the block busy: `busy`=0 from cycle F+1.
- `valid` is never high in two consecutive cycles.

## Test plan
- mul, `rs1`=7, `rs2`=6, accepted at T -> `valid` at T+33, `result`=42. Then mul 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
- mulh: 0x80000000*0x80000000 -> 0x40000000; 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF; 0x7FFFFFFF*0x7FFFFFFF -> 0x3FFFFFFF. Each has `valid` at T+33.
- Signed divide: div 0xFFFFFFF9/2 -> 0xFFFFFFFD; rem of the same -> 0xFFFFFFFF. Then divu 100/7 -> 14 and remu 100/7 -> 2.
- Fast path: divu 5/0 -> 0xFFFFFFFF; rem 5/0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000; mdu_op=111 -> 0. Each has `valid` at T+1 and `busy` low at T+2.
- Flush mid-op: `flush` at T+10 -> `busy`=0 at T+11, no `valid`, `result` retains its prior value. A new mul 3*3 started at T+11 yields 9 at T+44.
- Reset and ignore rules:
  - Asynchronous `rst` at T+20 -> outputs 0 immediately, with no clock edge needed.
  - `start` pulsed while `busy` -> exactly one `valid`, carrying the first op's result.

Source files
------------

// File: rtl/mdu_seq_if.sv
// Request/response bundle between the execute stage and the multiply/divide sequencer.
// The master issues operations and the slave (mdu_seq) reports busy/valid/result.
interface mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      mdu_op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, mdu_op, rs1, rs2, flush,
        input  busy, valid, result
    );

    modport slave (
        input  start, mdu_op, rs1, rs2, flush,
        output busy, valid, result
    );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring
// divide over XLEN iterations, with single-cycle resolution of the trivial cases.
module mdu_seq #(
    parameter int XLEN = 32
) (
    input logic       clk,
    input logic       rst,
    mdu_seq_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_MULH = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_DIVU = 3'b011;
    localparam logic [2:0] OP_REM  = 3'b100;
    localparam logic [2:0] OP_REMU = 3'b101;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] b_q;
    logic            valid_q;
    logic [XLEN-1:0] result_q;

    logic            signed_op;
    logic            is_mul;
    logic            sign1;
    logic            sign2;
    logic            neg_in;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            fast;
    logic [XLEN-1:0] fast_val;

    logic            op_is_mul;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_shift;
    logic            rem_ge;
    logic [XLEN-1:0] rem_diff;
    logic [XLEN-1:0] next_hi;
    logic [XLEN-1:0] next_lo;
    logic [XLEN-1:0] prod_hi_neg;
    logic [XLEN-1:0] final_val;

    assign bus.busy   = (state != S_IDLE);
    assign bus.valid  = valid_q;
    assign bus.result = result_q;

    // Operand magnitudes and result sign decided at acceptance so the core stays unsigned.
    always_comb begin
        signed_op = (bus.mdu_op == OP_MULH) || (bus.mdu_op == OP_DIV) || (bus.mdu_op == OP_REM);
        is_mul    = (bus.mdu_op == OP_MUL) || (bus.mdu_op == OP_MULH);
        sign1     = bus.rs1[XLEN-1];
        sign2     = bus.rs2[XLEN-1];
        mag1      = (signed_op && sign1) ? (~bus.rs1 + 1'b1) : bus.rs1;
        mag2      = (signed_op && sign2) ? (~bus.rs2 + 1'b1) : bus.rs2;
        if (bus.mdu_op == OP_REM) begin
            neg_in = sign1;
        end else begin
            neg_in = signed_op && (sign1 ^ sign2);
        end
    end

    always_comb begin
        fast     = 1'b0;
        fast_val = '0;
        if (bus.mdu_op[2] && bus.mdu_op[1]) begin
            fast     = 1'b1;
            fast_val = '0;
        end else if ((bus.mdu_op == OP_DIV || bus.mdu_op == OP_DIVU) && bus.rs2 == '0) begin
            fast     = 1'b1;
            fast_val = ALL_ONES;
        end else if ((bus.mdu_op == OP_REM || bus.mdu_op == OP_REMU) && bus.rs2 == '0) begin
            fast     = 1'b1;
            fast_val = bus.rs1;
        end else if (bus.rs1 == MIN_NEG && bus.rs2 == ALL_ONES) begin
            if (bus.mdu_op == OP_DIV) begin
                fast     = 1'b1;
                fast_val = MIN_NEG;
            end else if (bus.mdu_op == OP_REM) begin
                fast     = 1'b1;
                fast_val = '0;
            end
        end
    end

    // One iteration: multiply keeps {hi,lo} as the shifting product, divide keeps
    // hi as the partial remainder and lo as dividend bits turning into quotient bits.
    always_comb begin
        op_is_mul = (op_q == OP_MUL) || (op_q == OP_MULH);
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        rem_shift = {hi, lo[XLEN-1]};
        rem_ge    = (rem_shift >= {1'b0, b_q});
        rem_diff  = rem_shift[XLEN-1:0] - b_q;
        if (op_is_mul) begin
            next_hi = mul_sum[XLEN:1];
            next_lo = {mul_sum[0], lo[XLEN-1:1]};
        end else begin
            next_hi = rem_ge ? rem_diff : rem_shift[XLEN-1:0];
            next_lo = {lo[XLEN-2:0], rem_ge};
        end
    end

    // Upper half of the two's complement of {next_hi,next_lo}: carry only enters when the low half is zero.
    always_comb begin
        prod_hi_neg = ~next_hi + {{(XLEN-1){1'b0}}, (next_lo == '0)};
        case (op_q)
            OP_MUL:  final_val = next_lo;
            OP_MULH: final_val = neg_q ? prod_hi_neg : next_hi;
            OP_DIV:  final_val = neg_q ? (~next_lo + 1'b1) : next_lo;
            OP_DIVU: final_val = next_lo;
            OP_REM:  final_val = neg_q ? (~next_hi + 1'b1) : next_hi;
            OP_REMU: final_val = next_hi;
            default: final_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            b_q      <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (bus.flush) begin
                state <= S_IDLE;
                count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            if (fast) begin
                                result_q <= fast_val;
                                valid_q  <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                op_q  <= bus.mdu_op;
                                neg_q <= neg_in;
                                hi    <= '0;
                                lo    <= is_mul ? mag2 : mag1;
                                b_q   <= is_mul ? mag1 : mag2;
                                count <= '0;
                                state <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        hi    <= next_hi;
                        lo    <= next_lo;
                        count <= count + CW'(1);
                        if (count == CW'(XLEN-1)) begin
                            result_q <= final_val;
                            valid_q  <= 1'b1;
                            count    <= '0;
                            state    <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: hand-computed vectors with cycle-exact
// latency checks for the iterative, fast-path, flush, reset and ignore cases.
module tb_mdu_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   valid_seen;
    logic valid_prev;

    mdu_seq_if #(.XLEN(32)) bus ();

    mdu_seq #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count valid pulses and flag back-to-back valid cycles.
    always @(posedge clk) begin
        if (bus.valid) valid_seen <= valid_seen + 1;
        if (bus.valid && valid_prev) begin
            errors <= errors + 1;
            $display("[TB] FAIL valid_twice: observed 1 in consecutive cycles, required single pulse");
        end
        valid_prev <= bus.valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Holds the request for one edge; returns #1 into cycle T+1.
    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.mdu_op = op;
        bus.rs1    = a;
        bus.rs2    = b;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic run_iter(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] expected);
        apply_stimulus(op, a, b);
        check_output({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        repeat (31) tick();
        check_output({tag, "_early"}, {31'd0, bus.valid}, 32'd0);
        tick();
        check_output({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
        check_output({tag, "_result"}, bus.result, expected);
        tick();
        check_output({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic run_fast(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] expected);
        apply_stimulus(op, a, b);
        check_output({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
        check_output({tag, "_result"}, bus.result, expected);
        tick();
        check_output({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int base;
        checks     = 0;
        errors     = 0;
        valid_seen = 0;
        valid_prev = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.mdu_op = 3'b000;
        bus.rs1    = '0;
        bus.rs2    = '0;
        rst        = 1'b1;
        tick();
        tick();
        check_output("reset_busy", {31'd0, bus.busy}, 32'd0);
        check_output("reset_valid", {31'd0, bus.valid}, 32'd0);
        check_output("reset_result", bus.result, 32'd0);
        rst = 1'b0;
        tick();

        run_iter("mul_7x6", 3'b000, 32'd7, 32'd6, 32'd42);
        run_iter("mul_ones", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_iter("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_iter("mulh_neg", 3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
        run_iter("mulh_max", 3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF);
        run_iter("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_iter("rem_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_iter("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd14);
        run_iter("remu_100_7", 3'b101, 32'd100, 32'd7, 32'd2);

        // Flush in T+10 of a mul; result must still hold the remu value.
        base = valid_seen;
        apply_stimulus(3'b000, 32'd11, 32'd13);
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_output("flush_busy", {31'd0, bus.busy}, 32'd0);
        check_output("flush_result", bus.result, 32'd2);
        check_output("flush_no_valid", valid_seen - base, 32'd0);
        run_iter("mul_3x3", 3'b000, 32'd3, 32'd3, 32'd9);

        run_fast("divu_by0", 3'b011, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_fast("rem_by0", 3'b100, 32'd5, 32'd0, 32'd5);
        run_fast("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_fast("rem_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_fast("illegal", 3'b111, 32'd9, 32'd4, 32'd0);

        // A second start while busy must be ignored entirely.
        base = valid_seen;
        apply_stimulus(3'b011, 32'd50, 32'd5);
        repeat (4) tick();
        bus.mdu_op = 3'b000;
        bus.rs1    = 32'd2;
        bus.rs2    = 32'd2;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        repeat (27) tick();
        check_output("ignore_valid", {31'd0, bus.valid}, 32'd1);
        check_output("ignore_result", bus.result, 32'd10);
        repeat (3) tick();
        check_output("ignore_count", valid_seen - base, 32'd1);
        check_output("ignore_idle", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset mid-operation, observed before any clock edge.
        apply_stimulus(3'b000, 32'd5, 32'd5);
        repeat (19) tick();
        #1;
        rst = 1'b1;
        #1;
        check_output("arst_busy", {31'd0, bus.busy}, 32'd0);
        check_output("arst_valid", {31'd0, bus.valid}, 32'd0);
        check_output("arst_result", bus.result, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_fast("post_reset", 3'b101, 32'd77, 32'd0, 32'd77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
